// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program loader: FSM state encoding and the
// byte-stream format constants (header length, bytes per instruction word).
// Imported by the loader interface and the loader itself.
package prog_loader_pkg;

   // Loader FSM states
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LEN  = 3'd1,
      ST_DATA = 3'd2,
      ST_CHK  = 3'd3,
      ST_DONE = 3'd4,
      ST_ERR  = 3'd5
   } state_t;

   // Stream format: little-endian 16-bit word count, then 4 bytes per word
   localparam int unsigned HDR_BYTES      = 2;
   localparam int unsigned BYTES_PER_WORD = 4;

   // Bit offset of byte lane idx inside a 32-bit instruction word
   function automatic logic [4:0] byte_lane_lsb(input logic [1:0] idx);
      return {idx, 3'b000};
   endfunction

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream, instruction-memory write port and core-control bundle of the
// program loader. slave = loader side (consumes bytes, drives imem/status),
// master = host/testbench side (drives start and the byte stream).
interface prog_loader_if #(
   parameter int unsigned AW = 6
);
   logic          start;       // one-cycle load request
   logic          in_valid;    // byte-stream valid
   logic [7:0]    in_byte;     // byte-stream data
   logic          in_ready;    // byte-stream ready
   logic          imem_we;     // instruction-memory write strobe
   logic [AW-1:0] imem_addr;   // instruction-memory word address
   logic [31:0]   imem_wdata;  // instruction word to write
   logic          cpu_hold;    // keeps the core's PC and write enables frozen
   logic          done;        // load finished, checksum good
   logic          error;       // load failed

   modport slave (
      input  start, in_valid, in_byte,
      output in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

   modport master (
      output start, in_valid, in_byte,
      input  in_ready, imem_we, imem_addr, imem_wdata, cpu_hold, done, error
   );

endinterface

// File: rtl/prog_loader.sv
// Purpose : loads a program from a byte stream (2-byte LE word count N,
//           4*N LE instruction bytes, 1 XOR checksum byte) into the
//           instruction memory while holding the core; releases it on success.
// Ports   : clk, rst_n (sync, active-low); bus (prog_loader_if.slave):
//           start, in_valid/in_byte/in_ready byte stream, imem_we/imem_addr/
//           imem_wdata write port, cpu_hold, done, error.
// Latency : imem_we pulses the cycle after the 4th byte of a word; one byte
//           per cycle sustained, in_ready never drops for a memory write.
// imem_* connect to the instruction memory write port; cpu_hold gates the
// PC update (and RegWrite/MemWrite) in the CPU top level.
module prog_loader
   import prog_loader_pkg::*;
#(
   parameter int unsigned IMEM_WORDS = 64,
   parameter int unsigned AW         = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   prog_loader_if.slave    bus
);

   // ------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------
   state_t        r_state;
   logic [15:0]   r_len;        // word count N from the header
   logic          r_hdr_idx;    // which header byte comes next
   logic [1:0]    r_byte_idx;   // byte lane inside the current word
   logic [AW-1:0] r_addr;       // index of the word being assembled/written
   logic [7:0]    r_xor;        // running XOR of instruction bytes
   logic [31:0]   r_wdata;      // word assembly register, also imem_wdata
   logic          r_we;
   logic          r_in_ready;
   logic          r_cpu_hold;
   logic          r_done;
   logic          r_error;

   // ------------------------------------------------------------------
   // Combinational helpers
   // ------------------------------------------------------------------
   logic          w_acc;        // byte accepted this cycle
   logic [15:0]   w_len_full;   // complete N once the high header byte arrives
   logic          w_len_too_big;
   logic          w_last_word;  // current word is word N-1
   logic          w_last_hdr;
   logic          w_last_lane;

   assign w_acc         = bus.in_valid & r_in_ready;
   assign w_len_full    = {bus.in_byte, r_len[7:0]};
   assign w_len_too_big = ({16'd0, w_len_full} > IMEM_WORDS);
   assign w_last_word   = ((17'(r_addr) + 17'd1) == {1'b0, r_len});
   assign w_last_hdr    = (r_hdr_idx == 1'(HDR_BYTES - 1));
   assign w_last_lane   = (r_byte_idx == 2'(BYTES_PER_WORD - 1));

   // ------------------------------------------------------------------
   // Loader FSM
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_len      <= '0;
         r_hdr_idx  <= 1'b0;
         r_byte_idx <= '0;
         r_addr     <= '0;
         r_xor      <= '0;
         r_wdata    <= '0;
         r_we       <= 1'b0;
         r_in_ready <= 1'b0;
         r_cpu_hold <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
      end else begin
         // Write strobe is a single-cycle pulse by default
         r_we <= 1'b0;

         // Advance the word address only after the write cycle so imem_addr
         // still names the written word while imem_we is high. The final
         // word moves the FSM to CHK in the same edge, so the address is
         // left at N-1 and never wraps past the memory.
         if (r_we && (r_state == ST_DATA)) begin
            r_addr <= r_addr + AW'(1);
         end

         unique case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (bus.start) begin
                  r_state    <= ST_LEN;
                  r_len      <= '0;
                  r_hdr_idx  <= 1'b0;
                  r_byte_idx <= '0;
                  r_addr     <= '0;
                  r_xor      <= '0;
                  r_in_ready <= 1'b1;
                  r_cpu_hold <= 1'b1;
                  r_done     <= 1'b0;
                  r_error    <= 1'b0;
               end
            end

            ST_LEN: begin
               if (w_acc) begin
                  if (!w_last_hdr) begin
                     r_len[7:0] <= bus.in_byte;
                     r_hdr_idx  <= 1'b1;
                  end else begin
                     r_len[15:8] <= bus.in_byte;
                     if (w_len_too_big) begin
                        r_state    <= ST_ERR;
                        r_in_ready <= 1'b0;
                        r_error    <= 1'b1;
                     end else if (w_len_full == 16'd0) begin
                        // Empty program: only the checksum byte (0x00) follows
                        r_state <= ST_CHK;
                     end else begin
                        r_state <= ST_DATA;
                     end
                  end
               end
            end

            ST_DATA: begin
               if (w_acc) begin
                  r_wdata[byte_lane_lsb(r_byte_idx) +: 8] <= bus.in_byte;
                  r_xor      <= r_xor ^ bus.in_byte;
                  r_byte_idx <= r_byte_idx + 2'd1;
                  if (w_last_lane) begin
                     r_we <= 1'b1;
                     if (w_last_word) begin
                        r_state <= ST_CHK;
                     end
                  end
               end
            end

            ST_CHK: begin
               if (w_acc) begin
                  r_in_ready <= 1'b0;
                  if (bus.in_byte == r_xor) begin
                     r_state    <= ST_DONE;
                     r_done     <= 1'b1;
                     r_cpu_hold <= 1'b0;
                  end else begin
                     r_state <= ST_ERR;
                     r_error <= 1'b1;
                  end
               end
            end

            default: begin
               r_state    <= ST_IDLE;
               r_in_ready <= 1'b0;
               r_cpu_hold <= 1'b1;
               r_done     <= 1'b0;
               r_error    <= 1'b0;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   assign bus.in_ready   = r_in_ready;
   assign bus.imem_we    = r_we;
   assign bus.imem_addr  = r_addr;
   assign bus.imem_wdata = r_wdata;
   assign bus.cpu_hold   = r_cpu_hold;
   assign bus.done       = r_done;
   assign bus.error      = r_error;

endmodule
